if_stage: RTL

- Instruction-fetch stage directly upstream of the IF/ID register and decode.
- Owns the PC and assembles each 32-bit instruction from four byte reads through the byte-wide memory-controller port.
- Hands {pc, inst} to IF/ID with a valid flag and holds them under stall.
- Redirects to the EX jump/branch target, aborting any fetch in flight.

---
 rtl/if_stage_pkg.sv | 23 ++
 rtl/if_stage.sv | 125 ++++++++++++
 2 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: datapath widths and
// the fetch FSM state encoding.
package if_stage_pkg;

    localparam int AddrLen = 32;
    localparam int InstLen = 32;
    localparam logic [InstLen-1:0] ZERO_WORD = '0;

    // Four byte beats per instruction need a 2-bit beat counter.
    localparam int ByteCntLen   = 2;
    localparam int BytesPerInst = InstLen / 8;

    typedef enum logic {
        IF_FETCH = 1'b0,
        IF_DONE  = 1'b1
    } if_state_t;

    // Instructions are word aligned; redirect targets drop their low two bits.
    function automatic logic [AddrLen-1:0] word_align(input logic [AddrLen-1:0] addr);
        return {addr[AddrLen-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, assembles each instruction from four
// byte reads, and presents {pc, inst} to IF/ID, holding it under stall.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int                  ADDR_LEN = AddrLen,
    parameter int                  INST_LEN = InstLen,
    parameter logic [ADDR_LEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic                mem_req_o,
    output logic [ADDR_LEN-1:0] mem_addr_o,
    input  logic                mem_ack_i,
    input  logic [7:0]          mem_data_i,
    input  logic                jump_i,
    input  logic [ADDR_LEN-1:0] jump_addr_i,
    input  logic                stall_i,
    output logic [ADDR_LEN-1:0] pc_o,
    output logic [INST_LEN-1:0] inst_o,
    output logic                inst_valid_o,
    output logic                stall_if_o
);

    localparam int NumLanes = INST_LEN / 8;

    if_state_t             state_reg, state_next;
    logic [ADDR_LEN-1:0]   pc_reg, pc_next;
    logic [ByteCntLen-1:0] byte_cnt_reg, byte_cnt_next;
    logic [INST_LEN-9:0]   buf_reg, buf_next;
    logic [ADDR_LEN-1:0]   pc_out_reg, pc_out_next;
    logic [INST_LEN-1:0]   inst_out_reg, inst_out_next;
    logic                  valid_reg, valid_next;

    logic                  capture;
    logic                  last_byte;
    logic [NumLanes-2:0]   lane_we;

    // A beat is only accepted when no redirect is happening the same cycle.
    assign capture   = (state_reg == IF_FETCH) && mem_ack_i && !jump_i;
    assign last_byte = (byte_cnt_reg == ByteCntLen'(NumLanes - 1));

    // The final byte goes straight into the output word, so only the lower
    // lanes need buffering.
    genvar gi;
    generate
        for (gi = 0; gi < NumLanes - 1; gi++) begin : g_lane
            assign lane_we[gi] = capture && (byte_cnt_reg == ByteCntLen'(gi));
            assign buf_next[gi*8 +: 8] = lane_we[gi] ? mem_data_i : buf_reg[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        byte_cnt_next = byte_cnt_reg;
        pc_out_next   = pc_out_reg;
        inst_out_next = inst_out_reg;
        valid_next    = valid_reg;

        if (jump_i) begin
            pc_next       = {jump_addr_i[ADDR_LEN-1:2], 2'b00};
            state_next    = IF_FETCH;
            byte_cnt_next = '0;
            valid_next    = 1'b0;
        end else begin
            case (state_reg)
                IF_FETCH: begin
                    if (mem_ack_i) begin
                        if (last_byte) begin
                            state_next    = IF_DONE;
                            byte_cnt_next = '0;
                            valid_next    = 1'b1;
                            pc_out_next   = pc_reg;
                            inst_out_next = {mem_data_i, buf_reg};
                            pc_next       = pc_reg + ADDR_LEN'(NumLanes);
                        end else begin
                            byte_cnt_next = byte_cnt_reg + ByteCntLen'(1);
                        end
                    end
                end
                IF_DONE: begin
                    if (!stall_i) begin
                        state_next    = IF_FETCH;
                        byte_cnt_next = '0;
                        valid_next    = 1'b0;
                    end
                end
                default: begin
                    state_next    = IF_FETCH;
                    byte_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IF_FETCH;
            pc_reg       <= RESET_PC;
            byte_cnt_reg <= '0;
            buf_reg      <= '0;
            pc_out_reg   <= '0;
            inst_out_reg <= '0;
            valid_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            byte_cnt_reg <= byte_cnt_next;
            buf_reg      <= buf_next;
            pc_out_reg   <= pc_out_next;
            inst_out_reg <= inst_out_next;
            valid_reg    <= valid_next;
        end
    end

    // Gated by rst so the request drops the instant reset is asserted.
    assign mem_req_o    = rst && (state_reg == IF_FETCH);
    assign mem_addr_o   = pc_reg + ADDR_LEN'(byte_cnt_reg);
    assign stall_if_o   = (state_reg == IF_FETCH);
    assign pc_o         = pc_out_reg;
    assign inst_o       = inst_out_reg;
    assign inst_valid_o = valid_reg;

endmodule
